// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - nibble-serial command sequencer wrapped around the combinational 4-bit alu
module alu_seq #(
  parameter int NIB = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*NIB-1:0]   in_a,
  input  logic [4*NIB-1:0]   in_b,
  input  logic               in_cin,
  input  logic               in_l,
  input  logic [1:0]         in_aluop,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic               alu_cin,
  output logic               alu_l,
  output logic [1:0]         alu_op,
  input  logic [3:0]         alu_r,
  input  logic               alu_zero,
  input  logic               alu_cout,
  input  logic               alu_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*NIB-1:0]   out_r,
  output logic               out_zero,
  output logic               out_cout,
  output logic               out_sign
);

  localparam int W  = 4 * NIB;
  // index width is kept at least one bit so NIB=1 still has a legal vector
  localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // latched command
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          cin_reg;
  logic          l_reg;
  logic [1:0]    op_reg;

  // progress and accumulated result
  logic [KW-1:0] k;
  logic [W-1:0]  r_reg;
  logic          zacc;
  logic          carry;
  logic          sign_reg;

  // selected operand nibbles for the current index
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;

  logic          accept;
  logic          last_nib;
  logic          chain;

  assign accept   = (state == IDLE) && in_valid;
  assign last_nib = (k == LAST_K);
  // only the arithmetic add ripples carry across nibbles; everything else is nibble-parallel
  assign chain    = !l_reg && (op_reg == 2'b10);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last_nib)  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // pick the operand nibbles addressed by k
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (k == KW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  // outputs: handshakes and ALU drive depend only on registered state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    alu_l     = 1'b0;
    alu_op    = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        alu_a   = a_nib;
        alu_b   = b_nib;
        alu_l   = l_reg;
        alu_op  = op_reg;
        alu_cin = (chain && (k != '0)) ? carry : cin_reg;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // command latch, nibble index and result/flag accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      cin_reg  <= 1'b0;
      l_reg    <= 1'b0;
      op_reg   <= '0;
      k        <= '0;
      r_reg    <= '0;
      zacc     <= 1'b0;
      carry    <= 1'b0;
      sign_reg <= 1'b0;
    end else begin
      if (accept) begin
        a_reg   <= in_a;
        b_reg   <= in_b;
        cin_reg <= in_cin;
        l_reg   <= in_l;
        op_reg  <= in_aluop;
        k       <= '0;
        zacc    <= 1'b1;
      end
      if (state == RUN) begin
        for (int i = 0; i < NIB; i++) begin
          if (k == KW'(i)) begin
            r_reg[4*i +: 4] <= alu_r;
          end
        end
        zacc     <= zacc & alu_zero;
        carry    <= alu_cout;
        sign_reg <= alu_sign;
        // wrap explicitly so non-power-of-two NIB never leaves k out of range
        k        <= last_nib ? '0 : k + KW'(1);
      end
    end
  end

  assign out_r    = r_reg;
  assign out_zero = zacc;
  assign out_cout = carry;
  assign out_sign = sign_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed table-driven bench for alu_seq with a behavioural 4-bit alu
module tb_alu_seq;

  localparam int NIB = 2;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_l;
  logic [1:0]   in_aluop;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_cin;
  logic         alu_l;
  logic [1:0]   alu_op;
  logic [3:0]   alu_r;
  logic         alu_zero;
  logic         alu_cout;
  logic         alu_sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_r;
  logic         out_zero;
  logic         out_cout;
  logic         out_sign;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.NIB(NIB)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_l(in_l), .in_aluop(in_aluop),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_l(alu_l), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_sign(alu_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_zero(out_zero), .out_cout(out_cout), .out_sign(out_sign)
  );

  always #5 clk = ~clk;

  // behavioural alu: l=0 {a+cin, a+~b+cin, a+b+cin, a+1+cin}; l=1 {and, or, xor, not a}
  logic [4:0] sum;
  always_comb begin
    sum      = '0;
    alu_r    = '0;
    alu_cout = 1'b0;
    if (!alu_l) begin
      case (alu_op)
        2'b00: sum = {1'b0, alu_a} + {4'b0, alu_cin};
        2'b01: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
        2'b10: sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        default: sum = {1'b0, alu_a} + 5'd1 + {4'b0, alu_cin};
      endcase
      alu_r    = sum[3:0];
      alu_cout = sum[4];
    end else begin
      case (alu_op)
        2'b00: alu_r = alu_a & alu_b;
        2'b01: alu_r = alu_a | alu_b;
        2'b10: alu_r = alu_a ^ alu_b;
        default: alu_r = ~alu_a;
      endcase
    end
  end
  assign alu_zero = (alu_r == 4'h0);
  assign alu_sign = alu_r[3];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       l;
    logic [1:0] op;
    logic [1:0] cinseq;   // expected alu_cin for {nibble1, nibble0}
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       s;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_cin   = v.cin;
    in_l     = v.l;
    in_aluop = v.op;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    in_l     = 1'b0;
    in_aluop = '0;
  endtask

  // issue one command, check every RUN cycle and the result; optionally complete the handshake
  task automatic apply(input vec_t v, input bit release_it);
    @(negedge clk);
    chk("ready_before_cmd", 32'(in_ready), 32'd1);
    drive_cmd(v);
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < NIB; k++) begin
      chk("alu_drive", 32'({alu_l, alu_op, alu_a, alu_b, alu_cin}),
          32'({v.l, v.op, v.a[4*k +: 4], v.b[4*k +: 4], v.cinseq[k]}));
      chk("valid_in_run", 32'({out_valid, in_ready}), 32'd0);
      @(negedge clk);
    end
    chk("valid_done", 32'({out_valid, in_ready}), 32'b10);
    chk("out_r", 32'(out_r), 32'(v.r));
    chk("flags_zcs", 32'({out_zero, out_cout, out_sign}), 32'({v.z, v.c, v.s}));
    chk("alu_idle_in_done", 32'({alu_l, alu_op, alu_a, alu_b, alu_cin}), 32'd0);
    if (release_it) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("back_to_idle", 32'({out_valid, in_ready}), 32'b01);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{8'h3A, 8'h47, 1'b0, 1'b0, 2'b10, 2'b10, 8'h81, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{8'hF0, 8'h10, 1'b0, 1'b0, 2'b10, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{8'h25, 8'h00, 1'b0, 1'b0, 2'b11, 2'b00, 8'h36, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 2'b10, 2'b11, 8'h01, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{8'hC3, 8'hA5, 1'b0, 1'b1, 2'b00, 2'b00, 8'h81, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{8'h5A, 8'h5A, 1'b0, 1'b1, 2'b10, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{8'h75, 8'h32, 1'b1, 1'b0, 2'b01, 2'b11, 8'h43, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{8'h8E, 8'h00, 1'b1, 1'b0, 2'b11, 2'b11, 8'hA0, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{8'hE4, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'hE4, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{8'h0F, 8'h30, 1'b0, 1'b1, 2'b01, 2'b00, 8'h3F, 1'b0, 1'b0, 1'b0};
    vt[10] = '{8'hF0, 8'h00, 1'b1, 1'b1, 2'b11, 2'b11, 8'h0F, 1'b0, 1'b0, 1'b0};

    reset     = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({out_valid, out_r, out_zero, out_cout, out_sign}), 32'd0);
    chk("reset_alu", 32'({alu_l, alu_op, alu_a, alu_b, alu_cin}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      apply(vt[i], 1'b1);
    end

    // backpressure: result held while a competing command is offered and must be dropped
    apply(vt[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_a     = 8'hFF;
      in_b     = 8'hFF;
      in_aluop = 2'b10;
      @(negedge clk);
      chk("bp_hold", 32'({out_valid, in_ready, out_r, out_zero, out_cout, out_sign}),
          32'({1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1}));
    end
    idle_inputs();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", 32'({out_valid, in_ready}), 32'b01);
    repeat (2) begin
      @(negedge clk);
      chk("bp_dropped", 32'({out_valid, in_ready, alu_a, alu_b}), 32'({1'b0, 1'b1, 8'h00}));
    end

    // reset after nibble 0 of a carrying add aborts the operation
    @(negedge clk);
    drive_cmd(vt[3]);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrun_reset_out", 32'({out_valid, out_r}), 32'd0);
    chk("midrun_reset_alu", 32'({alu_l, alu_op, alu_a, alu_b, alu_cin}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("aborted_no_valid", 32'({out_valid, in_ready}), 32'b01);
    end
    apply(vt[1], 1'b1);
    apply(vt[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle command sequencer that drives the 4-bit `alu` block and consumes its outputs. It accepts a `4*NIB`-bit operation over a valid/ready handshake and steps the ALU through the operands one nibble per cycle, least significant nibble first. For add operations it chains the carry between nibbles. It then returns the assembled result and flags over a second valid/ready handshake. It sits between the datapath control and the 4-bit ALU, which stays combinational.

## Interface
- `NIB`, default 2: number of nibbles per operand; legal range 1..8; operand width is `W = 4*NIB`.

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  command present
- `in_ready`  out  1  sequencer can accept a command
- `in_a`, `in_b`  in  W  operands
- `in_cin`  in  1  carry-in for nibble 0
- `in_l`  in  1  ALU logic/arithmetic select (1 = logic unit)
- `in_aluop`  in  2  ALU operation code
- `alu_a`, `alu_b`  out  4  current nibble of the operands, to the ALU
- `alu_cin`  out  1  ALU carry-in
- `alu_l`  out  1  ALU logic/arithmetic select
- `alu_op`  out  2  ALU operation code
- `alu_r`  in  4  ALU result
- `alu_zero`, `alu_cout`, `alu_sign`  in  1  ALU flags
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `out_r`  out  W  assembled result
- `out_zero`, `out_cout`, `out_sign`  out  1  whole-word flags

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - `in_ready=1`.
  - On `in_valid && in_ready`, the block latches `in_a`, `in_b`, `in_cin`, `in_l` and `in_aluop`, clears the nibble index `k` to 0, sets the zero-accumulator to 1, and moves to RUN.
- RUN, per cycle for nibble `k`:
  - `alu_a = A[4k+3:4k]`, `alu_b = B[4k+3:4k]`.
  - `alu_l` and `alu_op` are the latched codes.
  - `alu_cin` is the latched `in_cin` when `k=0`.
  - For `k>0`, `alu_cin` is the registered `alu_cout` of nibble `k-1`, but only when `l=0` and `aluop=2'b10` (add). For every other code, `alu_cin` is the latched `in_cin` on every nibble (nibble-parallel).
  - At the clock edge:
    - `R[4k+3:4k] <= alu_r`.
    - zero-accumulator `<= zacc & alu_zero`.
    - carry register `<= alu_cout`.
    - `k <= k+1`.
  - After nibble `NIB-1`, the block moves to DONE.
  - Final `out_cout` is the `alu_cout` of the last nibble.
  - `out_sign` is the `alu_sign` of the last nibble.
  - `out_zero` is the zero-accumulator, i.e. all nibbles zero.
- DONE
  - `out_valid=1`, `in_ready=0`.
  - `out_r` and all flags stay stable until `out_ready=1`. On that handshake the block moves to IDLE.
- In IDLE and DONE, `alu_a`, `alu_b`, `alu_cin`, `alu_l` and `alu_op` are all 0.
- `in_valid` outside IDLE is ignored. No command is queued.
- Reset values, asynchronous:
  - state = IDLE, `k=0`.
  - `out_r=0`, all `out_*` flags 0, `out_valid=0`.
  - `in_ready=1` after release.
  - all `alu_*` outputs 0.
- Reset asserted mid-RUN or in DONE aborts the operation. The partial result is discarded and `out_valid` is not asserted for it.

## Timing
- `alu_*` outputs are combinational from registered state and index only. They never depend on the `in_*` ports in the same cycle.
- The ALU path is `alu_*` → `alu` → `alu_r`/flags, sampled at the edge ending that cycle. It must close in one period.
- Command accepted at edge `t`: nibble `k` is driven during cycle `t+k`, and `out_valid` rises after edge `t+NIB`.
- Minimum command-to-command spacing is `NIB+2` cycles: RUN×NIB, DONE×1 (with `out_ready=1`), IDLE×1.
- `NIB=1`: single RUN cycle; carry chaining is not applicable.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → immediately `out_valid=0`, `out_r=8'h00`, all `alu_*` outputs 0; after release `in_ready=1`.
- **Chained add**, `NIB=2`, `l=0`, `aluop=10`, `in_a=8'h3A`, `in_b=8'h47`, `in_cin=0`:
  - Cycle t: `alu_a=4'hA`, `alu_b=4'h7`, `alu_cin=0`.
  - Cycle t+1: `alu_a=4'h3`, `alu_b=4'h4`, `alu_cin=1`.
  - Result: `out_r=8'h81`, `out_cout=0`, `out_sign=1`, `out_zero=0`, `out_valid` after edge t+2.
- **Overflow to zero:** add `8'hF0 + 8'h10`, `cin=0` → `out_r=8'h00`, `out_cout=1`, `out_zero=1`, `out_sign=0`.
- **Nibble-parallel code:** `l=0`, `aluop=11`, `in_a=8'h25`, `in_cin=0` → `alu_cin=0` in both RUN cycles, `out_r=8'h36`.
- **Backpressure:** hold `out_ready=0` for 5 cycles after `out_valid` → `out_r` and flags unchanged, `in_ready=0`, a concurrent `in_valid` command is dropped. Raising `out_ready` returns to IDLE the next cycle.
- **Reset mid-RUN:** assert `reset` after nibble 0 of an add → `out_valid` stays 0. The next command after release completes with correct result, unaffected by the aborted carry.
